// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide unit: MDcal operation codes,
// MDWrite (mthi/mtlo) codes, sequencer state encoding and default latencies.
package md_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULTS = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIVS  = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;

    localparam logic [1:0] MDW_NONE = 2'd0;
    localparam logic [1:0] MDW_HI   = 2'd1;
    localparam logic [1:0] MDW_LO   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2
    } md_state_t;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    function automatic logic is_mult(input logic [2:0] cal);
        return (cal == MD_MULTS) || (cal == MD_MULTU);
    endfunction

    function automatic logic is_div(input logic [2:0] cal);
        return (cal == MD_DIVS) || (cal == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational mult/div datapath producing the 64-bit {hi,lo} result.
// Ports: MDcal (op code), a (rs operand), b (rt operand), res ({hi,lo}).
import md_pkg::*;

module mdu_arith (
    input  logic [2:0]  MDcal,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] res
);

    logic [63:0] w_sa;
    logic [63:0] w_sb;
    logic [31:0] w_squo;
    logic [31:0] w_srem;
    logic        w_bzero;
    logic        w_ovf;

    assign w_sa    = {{32{a[31]}}, a};
    assign w_sb    = {{32{b[31]}}, b};
    // SV signed / and % truncate toward zero; remainder follows dividend.
    assign w_squo  = $signed(a) / $signed(b);
    assign w_srem  = $signed(a) % $signed(b);
    assign w_bzero = (b == 32'd0);
    assign w_ovf   = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    always_comb begin
        res = 64'd0;
        case (MDcal)
            MD_MULTS: res = w_sa * w_sb;
            MD_MULTU: res = {32'd0, a} * {32'd0, b};
            MD_DIVS: begin
                if (w_bzero)
                    res = {a, 32'hFFFF_FFFF};
                else if (w_ovf)
                    res = {32'd0, 32'h8000_0000};
                else
                    res = {w_srem, w_squo};
            end
            MD_DIVU: begin
                if (w_bzero)
                    res = {a, 32'hFFFF_FFFF};
                else
                    res = {a % b, a / b};
            end
            default: res = 64'd0;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage mult/div sequencer: fixed-latency countdown, HI/LO ownership, D-stall.
// Ports: clk, reset_n, start, MDcal, MDWrite, cancel, rs_val, rt_val,
//        d_md_use in; hi, lo, busy, stall out.
import md_pkg::*;

module mdu_ctrl #(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  MDcal,
    input  logic [1:0]  MDWrite,
    input  logic        cancel,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_md_use,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall
);

    localparam int MAXLAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW     = $clog2(MAXLAT + 1);

    md_state_t   r_state;
    logic [CW-1:0] r_count;
    logic [63:0] r_pend;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;

    logic [63:0] w_res;
    logic        w_acc;
    logic        w_wr_ok;

    mdu_arith u_arith (
        .MDcal (MDcal),
        .a     (rs_val),
        .b     (rt_val),
        .res   (w_res)
    );

    assign w_acc   = start & ~cancel;
    // A start in the same cycle always suppresses the mt write.
    assign w_wr_ok = ~start & ~cancel;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_pend  <= 64'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_busy  <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_acc && is_mult(MDcal)) begin
                        r_state <= ST_MULT;
                        r_count <= CW'(MULT_LAT);
                        r_pend  <= w_res;
                        r_busy  <= 1'b1;
                    end else if (w_acc && is_div(MDcal)) begin
                        r_state <= ST_DIV;
                        r_count <= CW'(DIV_LAT);
                        r_pend  <= w_res;
                        r_busy  <= 1'b1;
                    end else if (w_wr_ok) begin
                        if (MDWrite == MDW_HI)
                            r_hi <= rs_val;
                        else if (MDWrite == MDW_LO)
                            r_lo <= rs_val;
                    end
                end
                ST_MULT, ST_DIV: begin
                    if (r_count == CW'(1)) begin
                        r_hi    <= r_pend[63:32];
                        r_lo    <= r_pend[31:0];
                        r_state <= ST_IDLE;
                        r_count <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_count <= r_count - CW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_count <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign hi    = r_hi;
    assign lo    = r_lo;
    assign busy  = r_busy;
    assign stall = d_md_use & (r_busy | w_acc);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: directed vectors, intrusion, mt writes,
// cancel, randomized ops against a magnitude-based model, async reset.
module tb_mdu_ctrl;

    localparam logic [2:0] C_MS = 3'd1;
    localparam logic [2:0] C_MU = 3'd2;
    localparam logic [2:0] C_DS = 3'd3;
    localparam logic [2:0] C_DU = 3'd4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [2:0]  MDcal;
    logic [1:0]  MDWrite;
    logic        cancel;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_md_use;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    mdu_ctrl dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .MDcal    (MDcal),
        .MDWrite  (MDWrite),
        .cancel   (cancel),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .d_md_use (d_md_use),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .stall    (stall)
    );

    function automatic logic [63:0] model(input logic [2:0] c,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] ma, mb, q, r;
        logic [63:0] p;
        logic        na, nb;
        na = a[31];
        nb = b[31];
        ma = na ? (~a + 32'd1) : a;
        mb = nb ? (~b + 32'd1) : b;
        case (c)
            C_MU: return {32'd0, a} * {32'd0, b};
            C_MS: begin
                p = {32'd0, ma} * {32'd0, mb};
                return (na ^ nb) ? (~p + 64'd1) : p;
            end
            C_DU: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            C_DS: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return {32'd0, 32'h8000_0000};
                q = ma / mb;
                r = ma % mb;
                if (na ^ nb) q = ~q + 32'd1;
                if (na) r = ~r + 32'd1;
                return {r, q};
            end
            default: return 64'd0;
        endcase
    endfunction

    task automatic run_op(input string nm, input logic [2:0] c,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int lat,
                          input logic use_d, input logic intrude);
        int n;
        logic bad_st, bad_hold;
        logic [63:0] prev, e;
        prev = {hi, lo};
        bad_st = 0;
        bad_hold = 0;
        @(negedge clk);
        start = 1; MDcal = c; rs_val = a; rt_val = b;
        d_md_use = use_d;
        sb.push_back(exp);
        #1;
        checks++;
        if (stall !== use_d) begin
            errors++;
            $display("FAIL %s start_stall got %b want %b", nm, stall, use_d);
        end
        @(posedge clk);
        #1;
        start = 0; MDcal = 0;
        rs_val = $urandom; rt_val = $urandom;
        @(negedge clk);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            if (stall !== use_d) bad_st = 1;
            if ({hi, lo} !== prev) bad_hold = 1;
            if (intrude && n == 2) begin
                start = 1; MDcal = C_DS;
                MDWrite = 2'd2; rs_val = 32'hDEAD_BEEF;
                rt_val = 32'd3;
            end else begin
                start = 0; MDcal = 0; MDWrite = 0;
            end
            @(negedge clk);
        end
        start = 0; MDcal = 0; MDWrite = 0;
        checks++;
        if (n != lat) begin
            errors++;
            $display("FAIL %s busy_cycles got %0d want %0d", nm, n, lat);
        end
        checks++;
        if (bad_st || stall !== 1'b0) begin
            errors++;
            $display("FAIL %s stall_path got %b/%b want %b/0",
                     nm, bad_st, stall, use_d);
        end
        checks++;
        if (bad_hold) begin
            errors++;
            $display("FAIL %s hilo_early got changed want %h", nm, prev);
        end
        e = sb.pop_front();
        checks++;
        if ({hi, lo} !== e) begin
            errors++;
            $display("FAIL %s result got %h want %h", nm, {hi, lo}, e);
        end
        d_md_use = 0;
    endtask

    task automatic test_reset();
        reset_n = 0; start = 0; MDcal = 0; MDWrite = 0;
        cancel = 0; rs_val = 0; rt_val = 0; d_md_use = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({hi, lo, busy, stall} !== 66'd0) begin
            errors++;
            $display("FAIL reset got %h %h %b %b want 0", hi, lo, busy, stall);
        end
        reset_n = 1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_op("mult", C_MS, 32'hFFFF_FFFE, 32'd3,
               64'hFFFF_FFFF_FFFF_FFFA, 5, 0, 0);
        run_op("multu", C_MU, 32'hFFFF_FFFE, 32'd3,
               64'h0000_0002_FFFF_FFFA, 5, 0, 0);
        run_op("div", C_DS, 32'hFFFF_FFF9, 32'd2,
               64'hFFFF_FFFF_FFFF_FFFD, 10, 0, 0);
        run_op("divu0", C_DU, 32'd7, 32'd0,
               64'h0000_0007_FFFF_FFFF, 10, 0, 0);
        run_op("divs0", C_DS, 32'hFFFF_FFF0, 32'd0,
               64'hFFFF_FFF0_FFFF_FFFF, 10, 0, 0);
        run_op("divovf", C_DS, 32'h8000_0000, 32'hFFFF_FFFF,
               64'h0000_0000_8000_0000, 10, 0, 0);
    endtask

    task automatic test_stall();
        run_op("stall_div", C_DS, 32'd100, 32'hFFFF_FFF9,
               64'h0000_0002_FFFF_FFF2, 10, 1, 0);
    endtask

    task automatic test_back_to_back();
        run_op("b2b_mult", C_MU, 32'd6, 32'd7, 64'd42, 5, 0, 1);
        run_op("b2b_div", C_DU, 32'd100, 32'd7,
               {32'd2, 32'd14}, 10, 1, 1);
    endtask

    task automatic test_mt();
        logic [31:0] old_lo, old_hi;
        old_lo = lo;
        @(negedge clk);
        MDWrite = 2'd1; rs_val = 32'h1234;
        @(negedge clk);
        MDWrite = 0;
        checks++;
        if (hi !== 32'h1234 || lo !== old_lo) begin
            errors++;
            $display("FAIL mthi got %h/%h want 00001234/%h", hi, lo, old_lo);
        end
        MDWrite = 2'd2; rs_val = 32'h5678;
        @(negedge clk);
        MDWrite = 2'd3; rs_val = 32'hAAAA_5555;
        checks++;
        if (lo !== 32'h5678 || hi !== 32'h1234) begin
            errors++;
            $display("FAIL mtlo got %h/%h want 00001234/00005678", hi, lo);
        end
        @(negedge clk);
        MDWrite = 0;
        checks++;
        if ({hi, lo} !== 64'h0000_1234_0000_5678) begin
            errors++;
            $display("FAIL mw3 got %h want 0000123400005678", {hi, lo});
        end
        old_hi = hi;
        old_lo = lo;
        start = 1; MDcal = C_MU; MDWrite = 2'd1;
        rs_val = 32'd2; rt_val = 32'd3;
        @(negedge clk);
        start = 0; MDcal = 0; MDWrite = 0;
        checks++;
        if (busy !== 1'b1 || hi !== old_hi) begin
            errors++;
            $display("FAIL start_wins got %b/%h want 1/%h", busy, hi, old_hi);
        end
        repeat (6) @(negedge clk);
        checks++;
        if ({hi, lo} !== 64'd6) begin
            errors++;
            $display("FAIL start_wins_res got %h want 6", {hi, lo});
        end
    endtask

    task automatic test_cancel();
        logic [63:0] prev;
        prev = {hi, lo};
        @(negedge clk);
        start = 1; cancel = 1; MDcal = C_MS; d_md_use = 1;
        rs_val = 32'd9; rt_val = 32'd9;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL cancel_stall got %b want 0", stall);
        end
        @(negedge clk);
        start = 0; MDWrite = 2'd1; d_md_use = 0;
        checks++;
        if (busy !== 1'b0 || {hi, lo} !== prev) begin
            errors++;
            $display("FAIL cancel_start got %b/%h want 0/%h",
                     busy, {hi, lo}, prev);
        end
        @(negedge clk);
        MDWrite = 0; cancel = 0;
        checks++;
        if (hi !== prev[63:32]) begin
            errors++;
            $display("FAIL cancel_mt got %h want %h", hi, prev[63:32]);
        end
        start = 1; MDcal = 3'd6;
        @(negedge clk);
        start = 0; MDcal = 0;
        checks++;
        if (busy !== 1'b0 || {hi, lo} !== prev) begin
            errors++;
            $display("FAIL bad_cal got %b/%h want 0/%h", busy, {hi, lo}, prev);
        end
    endtask

    task automatic test_random();
        logic [31:0] vals [6];
        logic [31:0] a, b;
        logic [2:0] c;
        vals[0] = 32'd0;
        vals[1] = 32'hFFFF_FFFF;
        vals[2] = 32'h8000_0000;
        vals[3] = 32'd13;
        vals[4] = 32'h7FFF_FFFF;
        vals[5] = 32'hFFFF_FFF3;
        for (int i = 0; i < 10; i++) begin
            c = 3'($urandom_range(1, 4));
            a = (i % 2) ? $urandom : vals[$urandom_range(0, 5)];
            b = (i % 3) ? $urandom : vals[$urandom_range(0, 5)];
            run_op("rand", c, a, b, model(c, a, b),
                   (c <= C_MU) ? 5 : 10, 1'(i % 2), 0);
        end
    endtask

    task automatic test_async_reset();
        logic [63:0] prev;
        @(negedge clk);
        MDWrite = 2'd1; rs_val = 32'hCAFE_0001;
        @(negedge clk);
        MDWrite = 0;
        prev = {hi, lo};
        start = 1; MDcal = C_MU; rs_val = 32'd5; rt_val = 32'd7;
        @(posedge clk);
        #1 start = 0; MDcal = 0;
        repeat (2) @(posedge clk);
        #2 reset_n = 0;
        #1;
        checks++;
        if (busy !== 1'b0 || {hi, lo} !== 64'd0 || prev == 64'd0) begin
            errors++;
            $display("FAIL async_rst got %b/%h want 0/0 (pre %h)",
                     busy, {hi, lo}, prev);
        end
        @(negedge clk);
        reset_n = 1;
        repeat (8) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || {hi, lo} !== 64'd0) begin
            errors++;
            $display("FAIL post_rst got %b/%h want 0/0", busy, {hi, lo});
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_back_to_back();
        test_mt();
        test_cancel();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule
